// File: rtl/io_reg_pkg.sv
// io_reg_pkg: shared types and limits for the AP3 IO serializer/deserializer stages.
package io_reg_pkg;

    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_e;

    localparam int SER_MAX_WIDTH = 32;

endpackage

// File: rtl/io_out_serializer.sv
// io_out_serializer: parallel-to-serial stage feeding the AP3 IO output register cell (OQI/OSEL).
module io_out_serializer
    import io_reg_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b0,
    parameter logic IDLE_LVL  = 1'b0
) (
    input  logic             IQC,
    input  logic             QRTN,
    input  logic [WIDTH-1:0] DATA_I,
    input  logic             VALID_I,
    output logic             READY_O,
    input  logic             OSEL_MODE_I,
    output logic             OQI_O,
    output logic             OSEL_O,
    output logic             BUSY_O,
    output logic             DONE_O
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > SER_MAX_WIDTH) begin : g_width_chk
        $error("io_out_serializer: WIDTH must be in 2..%0d", SER_MAX_WIDTH);
    end

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rdy_en_q;
    logic             oqi_q, oqi_d;
    logic             osel_q, osel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;

    function automatic logic head(input logic [WIDTH-1:0] d);
        return MSB_FIRST ? d[WIDTH-1] : d[0];
    endfunction

    // The register always holds the not-yet-driven bits with the next one at the head.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
        return MSB_FIRST ? (d << 1) : (d >> 1);
    endfunction

    assign READY_O = rdy_en_q & (state_q == SER_IDLE || cnt_q == LAST);
    assign accept  = VALID_I & READY_O;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        oqi_d   = oqi_q;
        osel_d  = osel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (accept) begin
            shreg_d = advance(DATA_I);
            oqi_d   = head(DATA_I);
            osel_d  = OSEL_MODE_I;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SER_SHIFT;
        end else if (state_q == SER_SHIFT) begin
            if (cnt_q == LAST) begin
                oqi_d   = IDLE_LVL;
                busy_d  = 1'b0;
                state_d = SER_IDLE;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                oqi_d   = head(shreg_q);
                shreg_d = advance(shreg_q);
                done_d  = (cnt_d == LAST);
            end
        end
    end

    always_ff @(posedge IQC or negedge QRTN) begin
        if (!QRTN) begin
            state_q  <= SER_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
            oqi_q    <= IDLE_LVL;
            osel_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
            oqi_q    <= oqi_d;
            osel_q   <= osel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign OQI_O  = oqi_q;
    assign OSEL_O = osel_q;
    assign BUSY_O = busy_q;
    assign DONE_O = done_q;

endmodule

// File: tb/tb_io_out_serializer.sv
// tb_io_out_serializer: directed checks of an LSB-first (idle 0) and an MSB-first (idle 1) serializer driven in parallel.
module tb_io_out_serializer;

    logic       IQC = 1'b0;
    logic       QRTN = 1'b1;
    logic [7:0] DATA_I = 8'h00;
    logic       VALID_I = 1'b0;
    logic       OSEL_MODE_I = 1'b0;
    logic       ready_l, oqi_l, osel_l, busy_l, done_l;
    logic       ready_m, oqi_m, osel_m, busy_m, done_m;
    int         errors = 0;
    int         checks = 0;

    always #5 IQC = ~IQC;

    io_out_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut (
        .IQC(IQC), .QRTN(QRTN), .DATA_I(DATA_I), .VALID_I(VALID_I), .READY_O(ready_l),
        .OSEL_MODE_I(OSEL_MODE_I), .OQI_O(oqi_l), .OSEL_O(osel_l), .BUSY_O(busy_l), .DONE_O(done_l)
    );

    io_out_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut_m (
        .IQC(IQC), .QRTN(QRTN), .DATA_I(DATA_I), .VALID_I(VALID_I), .READY_O(ready_m),
        .OSEL_MODE_I(OSEL_MODE_I), .OQI_O(oqi_m), .OSEL_O(osel_m), .BUSY_O(busy_m), .DONE_O(done_m)
    );

    typedef struct {
        logic [7:0] d;
        logic       os;
        logic [7:0] el;
        logic [7:0] em;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge IQC);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_l && n < 10) begin
            step();
            n++;
        end
        chk("ready_wait", ready_l, 1'b1);
        chk("ready_wait_m", ready_m, 1'b1);
    endtask

    task automatic check_idle(input logic os);
        chk("idle_oqi", oqi_l, 1'b0);
        chk("idle_oqi_m", oqi_m, 1'b1);
        chk("idle_busy", busy_l, 1'b0);
        chk("idle_done", done_l, 1'b0);
        chk("idle_osel", osel_l, os);
        chk("idle_ready", ready_l, 1'b1);
    endtask

    task automatic send(input logic [7:0] d, input logic os, input logic [7:0] el, input logic [7:0] em);
        DATA_I = d;
        OSEL_MODE_I = os;
        VALID_I = 1'b1;
        wait_ready();
        step();
        VALID_I = 1'b0;
        DATA_I = ~d;
        OSEL_MODE_I = ~os;
        for (int i = 0; i < 8; i++) begin
            chk("oqi", oqi_l, el[7-i]);
            chk("oqi_m", oqi_m, em[7-i]);
            chk("done", done_l, i == 7);
            chk("done_m", done_m, i == 7);
            chk("busy", busy_l, 1'b1);
            chk("osel", osel_l, os);
            chk("osel_m", osel_m, os);
            chk("ready_mid", ready_l, i == 7);
            if (i < 7) begin
                step();
                if (i == 3) OSEL_MODE_I = os;
            end
        end
        step();
        check_idle(os);
    endtask

    initial begin
        vt[0] = '{8'h00, 1'b0, 8'b00000000, 8'b00000000};
        vt[1] = '{8'hA5, 1'b0, 8'b10100101, 8'b10100101};
        vt[2] = '{8'h81, 1'b1, 8'b10000001, 8'b10000001};
        vt[3] = '{8'hC5, 1'b1, 8'b10100011, 8'b11000101};
        vt[4] = '{8'h01, 1'b0, 8'b10000000, 8'b00000001};

        // Reset release: READY stays low until the first edge after QRTN rises.
        #2 QRTN = 1'b0;
        VALID_I = 1'b1;
        DATA_I = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", ready_l, 1'b0);
            chk("rst_oqi", oqi_l, 1'b0);
            chk("rst_oqi_m", oqi_m, 1'b1);
            chk("rst_busy", busy_l, 1'b0);
        end
        QRTN = 1'b1;
        chk("rel_ready", ready_l, 1'b0);
        step();
        chk("first_edge_ready", ready_l, 1'b1);
        chk("first_edge_busy", busy_l, 1'b0);
        chk("first_edge_oqi_m", oqi_m, 1'b1);

        for (int v = 0; v < 5; v++) send(vt[v].d, vt[v].os, vt[v].el, vt[v].em);

        // Back-to-back F0 then 0F with VALID held: 16 contiguous bits, two DONE pulses.
        begin
            logic [15:0] exp_l, exp_m;
            exp_l = 16'b0000111111110000;
            exp_m = 16'b1111000000001111;
            DATA_I = 8'hF0;
            OSEL_MODE_I = 1'b0;
            VALID_I = 1'b1;
            wait_ready();
            step();
            for (int i = 0; i < 16; i++) begin
                chk("b2b_oqi", oqi_l, exp_l[15-i]);
                chk("b2b_oqi_m", oqi_m, exp_m[15-i]);
                chk("b2b_done", done_l, i == 7 || i == 15);
                chk("b2b_busy", busy_l, 1'b1);
                if (i == 7) DATA_I = 8'h0F;
                if (i == 8) VALID_I = 1'b0;
                if (i < 15) step();
            end
            step();
            check_idle(1'b0);
        end

        // Mid-word reset aborts asynchronously; a fresh word then goes out cleanly.
        DATA_I = 8'hFF;
        OSEL_MODE_I = 1'b1;
        VALID_I = 1'b1;
        wait_ready();
        step();
        VALID_I = 1'b0;
        step();
        step();
        chk("pre_rst_oqi", oqi_l, 1'b1);
        #1 QRTN = 1'b0;
        #1;
        chk("arst_oqi", oqi_l, 1'b0);
        chk("arst_oqi_m", oqi_m, 1'b1);
        chk("arst_busy", busy_l, 1'b0);
        chk("arst_done", done_l, 1'b0);
        chk("arst_ready", ready_l, 1'b0);
        chk("arst_osel", osel_l, 1'b0);
        step();
        step();
        QRTN = 1'b1;
        chk("arel_ready", ready_l, 1'b0);
        send(8'h01, 1'b0, 8'b10000000, 8'b00000001);

        // VALID raised mid-word is ignored until the DONE cycle, where the new word is taken.
        begin
            logic [15:0] exp_l, exp_m;
            exp_l = 16'b1010001110000000;
            exp_m = 16'b1100010100000001;
            DATA_I = 8'hC5;
            OSEL_MODE_I = 1'b0;
            VALID_I = 1'b1;
            wait_ready();
            step();
            VALID_I = 1'b0;
            for (int i = 0; i < 16; i++) begin
                chk("ign_oqi", oqi_l, exp_l[15-i]);
                chk("ign_oqi_m", oqi_m, exp_m[15-i]);
                chk("ign_done", done_l, i == 7 || i == 15);
                chk("ign_ready", ready_l, i == 7 || i == 15);
                if (i == 2) begin
                    VALID_I = 1'b1;
                    DATA_I = 8'h01;
                end
                if (i == 8) VALID_I = 1'b0;
                if (i < 15) step();
            end
            step();
            check_idle(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
